mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter_pick.sv | 12 +
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM/owner encodings and request record for the cache-to-memory arbiter
package mem_arbiter_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: D-cache, I-cache and main-memory signals around the arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [DATA_W-1:0] d_mem_writedata;
    logic [DATA_W-1:0] d_mem_readdata;
    logic              d_mem_BUSY;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [DATA_W-1:0] i_mem_readdata;
    logic              i_mem_BUSY;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_BUSY;
    modport master (
        output d_mem_read, d_mem_write, d_mem_address, d_mem_writedata,
        output i_mem_read, i_mem_address, mem_readdata, mem_BUSY,
        input  d_mem_readdata, d_mem_BUSY, i_mem_readdata, i_mem_BUSY,
        input  mem_read, mem_write, mem_address, mem_writedata
    );
    modport slave (
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_writedata,
        input  i_mem_read, i_mem_address, mem_readdata, mem_BUSY,
        output d_mem_readdata, d_mem_BUSY, i_mem_readdata, i_mem_BUSY,
        output mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// rr_pick2: two-way winner pick, round-robin against last_grant or fixed D-first
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic d_req,
    input  logic i_req,
    input  logic last_grant,
    input  logic rr_en,
    output logic grant
);
    always_comb grant = (d_req && i_req) ? (rr_en ? ~last_grant : OWN_D) : (i_req ? OWN_I : OWN_D);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises D-cache and I-cache block transfers onto one main-memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    mem_arbiter_if.slave bus
);
    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    mem_req_t          req_q, req_d, d_cand;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;
    logic              d_req, i_req, grant, active;

    assign d_req  = bus.d_mem_read | bus.d_mem_write;
    assign i_req  = bus.i_mem_read;
    assign active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    rr_pick2 u_pick (
        .d_req      (d_req),
        .i_req      (i_req),
        .last_grant (last_q),
        .rr_en      (RR_EN),
        .grant      (grant)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        req_d     = req_q;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        // a simultaneous read+write from the D-cache is treated as the write-back
        d_cand.rd    = bus.d_mem_read & ~bus.d_mem_write;
        d_cand.wr    = bus.d_mem_write;
        d_cand.addr  = bus.d_mem_address;
        d_cand.wdata = bus.d_mem_write ? bus.d_mem_writedata : '0;
        case (state_q)
            ST_IDLE: if (d_req || i_req) begin
                state_d = ST_ISSUE;
                owner_d = grant;
                last_d  = grant;
                req_d   = (grant == OWN_I) ? '{rd: 1'b1, wr: 1'b0, addr: bus.i_mem_address, wdata: '0} : d_cand;
            end
            ST_ISSUE: if (bus.mem_BUSY) state_d = ST_WAIT;
            ST_WAIT: if (!bus.mem_BUSY) begin
                state_d = ST_DONE;
                if (req_q.rd && owner_q == OWN_D) d_rdata_d = bus.mem_readdata;
                if (req_q.rd && owner_q == OWN_I) i_rdata_d = bus.mem_readdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_D;
            last_q    <= OWN_I;
            req_q     <= '0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            req_q     <= req_d;
            d_rdata_q <= d_rdata_d;
            i_rdata_q <= i_rdata_d;
        end
    end

    // memory-side outputs decode straight from state so reset drops them without a clock
    assign bus.mem_read       = active & req_q.rd;
    assign bus.mem_write      = active & req_q.wr;
    assign bus.mem_address    = active ? req_q.addr : '0;
    assign bus.mem_writedata  = active ? req_q.wdata : '0;
    assign bus.d_mem_readdata = d_rdata_q;
    assign bus.i_mem_readdata = i_rdata_q;
    assign bus.d_mem_BUSY     = d_req & ~(state_q == ST_DONE && owner_q == OWN_D);
    assign bus.i_mem_BUSY     = i_req & ~(state_q == ST_DONE && owner_q == OWN_I);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a variable-latency memory model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clock, reset;
  mem_arbiter_if bus ();
  mem_arbiter_if fb ();
  mem_arbiter #(.RR_EN(1'b1)) dut (.clock(clock), .reset(reset), .bus(bus));
  mem_arbiter #(.RR_EN(1'b0)) u_fix (.clock(clock), .reset(reset), .bus(fb));
  int checks = 0, passes = 0, fails = 0;
  int lat = 5;
  int cnt, n, d_grants;
  logic m_busy, m_done, f_busy, f_done, prev_active, prev_fix;
  logic [31:0] m_rdata;
  mem_req_t exp_q[$];
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [31:0] mdata(input logic [5:0] a);
    return (a == 6'h05) ? 32'hCAFEF00D : {16'hBEEF, 10'h0, a};
  endfunction
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; cnt <= 0; m_rdata <= '0;
    end else if (!(bus.mem_read || bus.mem_write)) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (!m_busy && !m_done) begin
      m_busy <= 1'b1; cnt <= lat - 1;
    end else if (m_busy) begin
      if (cnt == 0) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_rdata <= mdata(bus.mem_address);
      end else cnt <= cnt - 1;
    end
  end
  assign bus.mem_BUSY = m_busy;
  assign bus.mem_readdata = m_rdata;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      f_busy <= 1'b0; f_done <= 1'b0;
    end else if (!(fb.mem_read || fb.mem_write)) begin
      f_busy <= 1'b0; f_done <= 1'b0;
    end else if (!f_busy && !f_done) f_busy <= 1'b1;
    else if (f_busy) begin
      f_busy <= 1'b0; f_done <= 1'b1;
    end
  end
  assign fb.mem_BUSY = f_busy;
  assign fb.mem_readdata = mdata(fb.mem_address);
  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok === 1'b1) passes++;
    else begin
      fails++;
      $error("FAIL %s", tag);
    end
  endtask
  task automatic push(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] w);
    exp_q.push_back('{rd: rd, wr: wr, addr: a, wdata: w});
  endtask
  task automatic step();
    mem_req_t e;
    @(posedge clock); #1;
    if ((bus.mem_read || bus.mem_write) && !prev_active) begin
      chk("sb_nonempty", (exp_q.size() > 0) === 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("txn", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata} === {e.rd, e.wr, e.addr, e.wdata});
      end
    end
    prev_active = bus.mem_read || bus.mem_write;
  endtask
  task automatic wait_free(input logic is_i, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while ((is_i ? bus.i_mem_BUSY : bus.d_mem_BUSY) && k < 100);
    chk(is_i ? "i_busy_low" : "d_busy_low", (is_i ? bus.i_mem_BUSY : bus.d_mem_BUSY) === 1'b0);
    chk("mem_req_off_at_done", {bus.mem_read, bus.mem_write} === 2'b00);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    prev_active = 1'b0;
  endtask
  initial begin
    reset = 1'b1; prev_active = 1'b0; prev_fix = 1'b0; d_grants = 0;
    bus.d_mem_read = 0; bus.d_mem_write = 0; bus.d_mem_address = '0; bus.d_mem_writedata = '0;
    bus.i_mem_read = 0; bus.i_mem_address = '0;
    fb.d_mem_read = 0; fb.d_mem_write = 0; fb.d_mem_address = '0; fb.d_mem_writedata = '0;
    fb.i_mem_read = 0; fb.i_mem_address = '0;
    @(negedge clock);
    chk("rst_mem_req", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata} === 40'h0);
    chk("rst_busy", {bus.d_mem_BUSY, bus.i_mem_BUSY} === 2'b00);
    chk("rst_rdata", {bus.d_mem_readdata, bus.i_mem_readdata} === 64'h0);
    @(negedge clock);
    reset = 1'b0;
    lat = 5;
    bus.d_mem_read = 1; bus.d_mem_address = 6'h05; push(1, 0, 6'h05, '0);
    wait_free(0, n);
    chk("d_read_cycles", n === 8);
    chk("d_rdata_cafe", bus.d_mem_readdata === 32'hCAFEF00D);
    step();
    chk("d_busy_after_done", bus.d_mem_BUSY === 1'b1);
    bus.d_mem_read = 0;
    step();
    do_reset();
    lat = 2;
    bus.d_mem_read = 1; bus.d_mem_address = 6'h11; bus.i_mem_read = 1; bus.i_mem_address = 6'h22;
    push(1, 0, 6'h11, '0); push(1, 0, 6'h22, '0);
    wait_free(0, n);
    chk("tie_d_cycles", n === 5);
    chk("tie_d_rdata", bus.d_mem_readdata === mdata(6'h11));
    chk("tie_i_busy_at_d_done", bus.i_mem_BUSY === 1'b1);
    bus.d_mem_address = 6'h12; push(1, 0, 6'h12, '0);
    wait_free(1, n);
    chk("tie_i_cycles", n === 6);
    chk("tie_i_rdata", bus.i_mem_readdata === mdata(6'h22));
    chk("tie_d_busy_at_i_done", bus.d_mem_BUSY === 1'b1);
    bus.i_mem_read = 0;
    wait_free(0, n);
    chk("tie_d2_cycles", n === 6);
    chk("tie_d2_rdata", bus.d_mem_readdata === mdata(6'h12));
    bus.d_mem_read = 0;
    step();
    bus.d_mem_read = 1; bus.d_mem_write = 1; bus.d_mem_address = 6'h3F; bus.d_mem_writedata = 32'h12345678;
    push(0, 1, 6'h3F, 32'h12345678);
    step();
    bus.i_mem_read = 1; bus.i_mem_address = 6'h07; push(1, 0, 6'h07, '0);
    wait_free(0, n);
    chk("wb_cycles", n === 4);
    chk("d_rdata_hold_on_write", bus.d_mem_readdata === mdata(6'h12));
    bus.d_mem_write = 0; bus.d_mem_address = 6'h0A; push(1, 0, 6'h0A, '0);
    wait_free(1, n);
    chk("wb_i_cycles", n === 6);
    chk("wb_i_rdata", bus.i_mem_readdata === mdata(6'h07));
    bus.i_mem_read = 0;
    wait_free(0, n);
    chk("refill_cycles", n === 6);
    chk("refill_rdata", bus.d_mem_readdata === mdata(6'h0A));
    bus.d_mem_read = 0;
    step();
    lat = 4;
    bus.d_mem_read = 1; bus.d_mem_address = 6'h15; push(1, 0, 6'h15, '0);
    repeat (3) step();
    chk("drop_in_wait_req", bus.mem_read === 1'b1);
    bus.d_mem_read = 0;
    n = 3;
    do begin
      step();
      n++;
    end while (bus.mem_read && n < 100);
    chk("drop_done_cycles", n === 7);
    chk("drop_rdata", bus.d_mem_readdata === mdata(6'h15));
    chk("drop_d_busy", bus.d_mem_BUSY === 1'b0);
    step();
    lat = 6;
    bus.d_mem_read = 1; bus.d_mem_address = 6'h20; push(1, 0, 6'h20, '0);
    step();
    bus.i_mem_read = 1; bus.i_mem_address = 6'h30;
    step(); step();
    chk("pre_rst_req", bus.mem_read === 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_req", {bus.mem_read, bus.mem_write, bus.mem_address} === 8'h0);
    chk("async_rst_busy", {bus.d_mem_BUSY, bus.i_mem_BUSY} === 2'b11);
    chk("async_rst_rdata", {bus.d_mem_readdata, bus.i_mem_readdata} === 64'h0);
    @(negedge clock);
    reset = 1'b0; prev_active = 1'b0; lat = 2;
    push(1, 0, 6'h20, '0); push(1, 0, 6'h30, '0);
    wait_free(0, n);
    chk("post_rst_d_cycles", n === 5);
    chk("post_rst_d_rdata", bus.d_mem_readdata === mdata(6'h20));
    bus.d_mem_read = 0;
    wait_free(1, n);
    chk("post_rst_i_cycles", n === 6);
    chk("post_rst_i_rdata", bus.i_mem_readdata === mdata(6'h30));
    bus.i_mem_read = 0;
    step();
    chk("sb_drained", exp_q.size() === 0);
    fb.d_mem_read = 1; fb.d_mem_address = 6'h01; fb.i_mem_read = 1; fb.i_mem_address = 6'h02;
    repeat (30) begin
      step();
      if ((fb.mem_read || fb.mem_write) && !prev_fix) begin
        chk("fixed_owner_addr", fb.mem_address === 6'h01);
        d_grants++;
      end
      prev_fix = fb.mem_read || fb.mem_write;
    end
    chk("fixed_d_grants", d_grants === 6);
    chk("fixed_i_busy", fb.i_mem_BUSY === 1'b1);
    chk("fixed_i_rdata", fb.i_mem_readdata === 32'h0);
    chk("fixed_d_rdata", fb.d_mem_readdata === mdata(6'h01));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
